// File: rtl/range_session_scheduler.sv
// range_session_scheduler
//
// Shares one range-finder datapath between NREQ requesters. Sessions are
// granted round-robin. The grantee's samples are forwarded to the datapath as
// go / data / finish. The range is captured RESULT_LAT cycles after finish and
// returned tagged with the requester ID. A datapath error, an idle timeout or
// a requester dropping its request aborts the session. The datapath is then
// cleared with a one-cycle pulse and the abort is reported.
//
// Ports
//   clock, reset        clock; asynchronous active-low reset
//   req                 per-requester session request (level)
//   req_data            per-requester sample, slice i = [i*WIDTH +: WIDTH]
//   req_valid/req_last  per-requester sample valid / final-sample marker
//   grant               one-hot current owner (zero when none)
//   req_ready           sample accepted this cycle (grantee only, in STREAM)
//   rf_data/rf_go/rf_finish/rf_clear   registered datapath controls
//   rf_range/rf_error   datapath result and error flag
//   done/done_id/done_range/done_err   one-cycle result report
module range_session_scheduler #(
  parameter int WIDTH      = 16,
  parameter int NREQ       = 4,
  parameter int RESULT_LAT = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           grant,
  output logic [NREQ-1:0]           req_ready,
  output logic [WIDTH-1:0]          rf_data,
  output logic                      rf_go,
  output logic                      rf_finish,
  output logic                      rf_clear,
  input  logic [WIDTH-1:0]          rf_range,
  input  logic                      rf_error,
  output logic                      done,
  output logic [$clog2(NREQ)-1:0]   done_id,
  output logic [WIDTH-1:0]          done_range,
  output logic [1:0]                done_err
);

  localparam int IDW = $clog2(NREQ);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int LW  = $clog2(RESULT_LAT + 1);

  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LAT_INIT  = LW'(RESULT_LAT);
  localparam logic [1:0]    ERR_OK    = 2'b00;
  localparam logic [1:0]    ERR_DP    = 2'b01;
  localparam logic [1:0]    ERR_TO    = 2'b10;

  typedef enum logic [2:0] {IDLE, STREAM, FIN, WAIT, REPORT, RECOVER} state_t;

  state_t            state, state_n;
  logic [IDW-1:0]    gidx, gidx_n;
  logic [IDW-1:0]    ptr, ptr_n;
  logic              first, first_n;
  logic [TW-1:0]     idle_cnt, idle_n;
  logic [LW-1:0]     lat_cnt, lat_n;
  logic [1:0]        err_code, err_n;
  logic [NREQ-1:0]   grant_n;
  logic [WIDTH-1:0]  rf_data_n;
  logic              go_n, fin_n, clr_n;
  logic              done_n;
  logic [IDW-1:0]    done_id_n;
  logic [WIDTH-1:0]  done_range_n;
  logic [1:0]        done_err_n;

  logic [IDW:0]      sel;
  logic [IDW-1:0]    sel_idx;
  logic              beat;
  logic [WIDTH-1:0]  sample;

  // First requester at or after the pointer, wrapping. Scanning from the
  // farthest offset down lets the nearest set bit win. MSB = found.
  function automatic logic [IDW:0] pick(input logic [NREQ-1:0] r,
                                        input logic [IDW-1:0] p);
    logic [IDW:0] res;
    int idx;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(p) + i) % NREQ;
      if (r[idx]) res = {1'b1, IDW'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    sel     = pick(req, ptr);
    sel_idx = sel[IDW-1:0];
    sample  = req_data[gidx*WIDTH +: WIDTH];

    req_ready = '0;
    if (state == STREAM && req[gidx]) req_ready = grant;
    beat = req_ready[gidx] & req_valid[gidx];

    state_n      = state;
    gidx_n       = gidx;
    ptr_n        = ptr;
    first_n      = first;
    idle_n       = idle_cnt;
    lat_n        = lat_cnt;
    err_n        = err_code;
    grant_n      = grant;
    rf_data_n    = rf_data;
    go_n         = 1'b0;
    fin_n        = 1'b0;
    clr_n        = 1'b0;
    done_n       = 1'b0;
    done_id_n    = done_id;
    done_range_n = done_range;
    done_err_n   = done_err;

    case (state)
      IDLE: begin
        if (sel[IDW]) begin
          gidx_n  = sel_idx;
          grant_n = NREQ'(1) << sel_idx;
          ptr_n   = (sel_idx == IDW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
          first_n = 1'b1;
          idle_n  = '0;
          state_n = STREAM;
        end
      end
      STREAM: begin
        if (rf_error) begin
          err_n   = ERR_DP;
          clr_n   = 1'b1;
          state_n = RECOVER;
        end else if (!req[gidx]) begin
          // Requester gave up: handled exactly like a timeout.
          err_n   = ERR_TO;
          clr_n   = 1'b1;
          state_n = RECOVER;
        end else if (beat) begin
          rf_data_n = sample;
          go_n      = first;
          first_n   = 1'b0;
          idle_n    = '0;
          if (req_last[gidx]) begin
            // A single-beat session spends this cycle on go, so finish is
            // deferred to a second FIN cycle.
            fin_n   = ~first;
            state_n = FIN;
          end
        end else if (idle_cnt == IDLE_LAST) begin
          err_n   = ERR_TO;
          clr_n   = 1'b1;
          state_n = RECOVER;
        end else begin
          idle_n = idle_cnt + 1'b1;
        end
      end
      FIN: begin
        if (rf_error) begin
          err_n   = ERR_DP;
          clr_n   = 1'b1;
          state_n = RECOVER;
        end else if (rf_finish) begin
          lat_n   = LAT_INIT;
          state_n = WAIT;
        end else begin
          fin_n = 1'b1;
        end
      end
      WAIT: begin
        if (rf_error) begin
          err_n   = ERR_DP;
          clr_n   = 1'b1;
          state_n = RECOVER;
        end else if (lat_cnt <= LW'(1)) begin
          // Counter reaches zero on this cycle: range is valid now.
          done_n       = 1'b1;
          done_id_n    = gidx;
          done_range_n = rf_range;
          done_err_n   = ERR_OK;
          state_n      = REPORT;
        end else begin
          lat_n = lat_cnt - 1'b1;
        end
      end
      REPORT: begin
        grant_n = '0;
        state_n = IDLE;
      end
      RECOVER: begin
        done_n       = 1'b1;
        done_id_n    = gidx;
        done_range_n = '0;
        done_err_n   = err_code;
        state_n      = REPORT;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      gidx       <= '0;
      ptr        <= '0;
      first      <= 1'b0;
      idle_cnt   <= '0;
      lat_cnt    <= '0;
      err_code   <= ERR_OK;
      grant      <= '0;
      rf_data    <= '0;
      rf_go      <= 1'b0;
      rf_finish  <= 1'b0;
      rf_clear   <= 1'b0;
      done       <= 1'b0;
      done_id    <= '0;
      done_range <= '0;
      done_err   <= ERR_OK;
    end else begin
      state      <= state_n;
      gidx       <= gidx_n;
      ptr        <= ptr_n;
      first      <= first_n;
      idle_cnt   <= idle_n;
      lat_cnt    <= lat_n;
      err_code   <= err_n;
      grant      <= grant_n;
      rf_data    <= rf_data_n;
      rf_go      <= go_n;
      rf_finish  <= fin_n;
      rf_clear   <= clr_n;
      done       <= done_n;
      done_id    <= done_id_n;
      done_range <= done_range_n;
      done_err   <= done_err_n;
    end
  end

endmodule

// File: tb/tb_range_session_scheduler.sv
module tb_range_session_scheduler;
  localparam int W   = 16;
  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int TO  = 64;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*W-1:0]    req_data = '0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_last = '0;
  logic [N-1:0]      grant, req_ready;
  logic [W-1:0]      rf_data;
  logic              rf_go, rf_finish, rf_clear;
  logic [W-1:0]      rf_range;
  logic              rf_error = 1'b0;
  logic              done;
  logic [1:0]        done_id;
  logic [W-1:0]      done_range;
  logic [1:0]        done_err;

  range_session_scheduler #(.WIDTH(W), .NREQ(N), .RESULT_LAT(LAT), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data),
    .req_valid(req_valid), .req_last(req_last), .grant(grant),
    .req_ready(req_ready), .rf_data(rf_data), .rf_go(rf_go),
    .rf_finish(rf_finish), .rf_clear(rf_clear), .rf_range(rf_range),
    .rf_error(rf_error), .done(done), .done_id(done_id),
    .done_range(done_range), .done_err(done_err)
  );

  always #5 clock = ~clock;

  // Datapath stand-in: range is valid only RESULT_LAT cycles after finish.
  logic [LAT-1:0] fin_sh;
  logic [W-1:0]   model_range = '0;
  always @(posedge clock or negedge reset)
    if (!reset) fin_sh <= '0;
    else        fin_sh <= {fin_sh[LAT-2:0], rf_finish};
  assign rf_range = fin_sh[LAT-1] ? model_range : 16'hBEEF;

  int overlap = 0;
  always @(negedge clock) if (rf_go && rf_finish) overlap++;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [N-1:0]      mask;
    logic [2:0]        n;
    logic [3:0][W-1:0] s;
    logic [1:0]        g;
    logic [W-1:0]      rng;
  } sess_t;

  function automatic sess_t mk(input logic [N-1:0] mask, input int n,
                               input logic [W-1:0] s0, s1, s2, s3,
                               input int g, input logic [W-1:0] rng);
    sess_t t;
    t.mask = mask; t.n = 3'(n); t.s = {s3, s2, s1, s0};
    t.g = 2'(g); t.rng = rng;
    return t;
  endfunction

  task automatic wait_grant();
    int c;
    c = 0;
    @(negedge clock);
    while (grant == '0 && c < 20) begin @(negedge clock); c++; end
  endtask

  task automatic drive_one(input int ch, input logic [W-1:0] d, input logic l);
    req_valid = '0; req_last = '0;
    req_valid[ch] = 1'b1; req_last[ch] = l; req_data[ch*W +: W] = d;
  endtask

  // Full session: every requesting channel offers data, only the grantee
  // may be acknowledged.
  task automatic run_session(input sess_t t);
    int cyc;
    model_range = t.rng;
    req = t.mask;
    wait_grant();
    chk("grant", grant, 32'(N'(1) << t.g));
    for (int k = 0; k < t.n; k++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = t.mask[i];
        req_last[i]  = (i == t.g) ? (k == t.n - 1) : 1'b1;
        req_data[i*W +: W] = (i == t.g) ? t.s[k] : 16'h5555;
      end
      #1;
      chk("ready", req_ready, 32'(N'(1) << t.g));
      @(negedge clock);
      req_valid = '0; req_last = '0;
      chk("go", rf_go, (k == 0));
      chk("data", rf_data, t.s[k]);
    end
    if (t.n == 1) begin
      chk("fin_after_go", rf_finish, 0);
      @(negedge clock);
      chk("fin_data", rf_data, t.s[0]);
    end
    chk("fin", rf_finish, 1);
    cyc = 0;
    while (!done && cyc < 20) begin @(negedge clock); cyc++; end
    chk("latency", cyc, LAT + 1);
    chk("done_id", done_id, t.g);
    chk("done_range", done_range, t.rng);
    chk("done_err", done_err, 0);
    req = '0;
    @(negedge clock);
    chk("done_pulse", done, 0);
  endtask

  sess_t tbl[6];

  initial begin
    int cnt;

    tbl[0] = mk(4'b1011, 1, 16'd7, 0, 0, 0, 0, 16'd0);
    tbl[1] = mk(4'b1011, 1, 16'd7, 0, 0, 0, 1, 16'd0);
    tbl[2] = mk(4'b1011, 1, 16'd7, 0, 0, 0, 3, 16'd0);
    tbl[3] = mk(4'b1011, 1, 16'd7, 0, 0, 0, 0, 16'd0);
    tbl[4] = mk(4'b0100, 1, 16'd9, 0, 0, 0, 2, 16'd0);
    tbl[5] = mk(4'b0010, 4, 16'd5, 16'd20, 16'd3, 16'd12, 1, 16'd17);

    repeat (3) @(negedge clock);
    chk("rst_ctrl", {grant, req_ready, rf_go, rf_finish, rf_clear, done}, 0);
    chk("rst_data", {rf_data, done_range, done_id, done_err}, 0);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run_session(tbl[i]);

    // Datapath error while waiting for the result
    req = 4'b0001; model_range = 16'h1234;
    wait_grant();
    chk("err_grant", grant, 4'b0001);
    drive_one(0, 16'd4, 1'b1);
    @(negedge clock); req_valid = '0; req_last = '0;
    @(negedge clock);
    chk("err_fin", rf_finish, 1);
    @(negedge clock);
    rf_error = 1'b1;
    @(negedge clock);
    rf_error = 1'b0;
    chk("err_clear", rf_clear, 1);
    chk("err_no_done_yet", done, 0);
    @(negedge clock);
    chk("err_done", done, 1);
    chk("err_code", done_err, 2'b01);
    chk("err_range", done_range, 0);
    chk("err_id", done_id, 0);
    chk("err_clear_1cyc", rf_clear, 0);
    req = '0;
    run_session(mk(4'b0100, 1, 16'd9, 0, 0, 0, 2, 16'd0));

    // Idle timeout after one beat
    req = 4'b0001;
    wait_grant();
    chk("to_grant", grant, 4'b0001);
    drive_one(0, 16'd8, 1'b0);
    @(negedge clock); req_valid = '0;
    cnt = 1;
    while (!rf_clear && cnt < 200) begin @(negedge clock); cnt++; end
    chk("to_cycles", cnt, TO + 1);
    @(negedge clock);
    chk("to_done", done, 1);
    chk("to_id", done_id, 0);
    chk("to_code", done_err, 2'b10);
    chk("to_range", done_range, 0);
    req = '0;

    // Requester drops its request mid-session
    req = 4'b0001;
    wait_grant();
    chk("drop_grant", grant, 4'b0001);
    drive_one(0, 16'd6, 1'b0);
    @(negedge clock); req_valid = '0; req = '0;
    @(negedge clock);
    chk("drop_clear", rf_clear, 1);
    @(negedge clock);
    chk("drop_done", done, 1);
    chk("drop_code", done_err, 2'b10);
    chk("drop_id", done_id, 0);

    // Asynchronous reset in the middle of a stream
    @(negedge clock);
    req = 4'b0100;
    wait_grant();
    chk("ar_grant", grant, 4'b0100);
    drive_one(2, 16'd50, 1'b0);
    @(negedge clock); req_valid = '0;
    chk("ar_go", rf_go, 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_ctrl", {grant, req_ready, rf_go, rf_finish, rf_clear, done}, 0);
    chk("ar_data", {rf_data, done_range, done_err}, 0);
    req = 4'b1100;
    @(negedge clock);
    chk("ar_clear_low", rf_clear, 0);
    reset = 1'b1;
    wait_grant();
    chk("ar_ptr0", grant, 4'b0100);
    req = '0;
    repeat (3) @(negedge clock);

    chk("go_fin_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
